// File: rtl/otp_ctrl_pkg.sv
// Shared definitions for the OTP controller life cycle programming stage.
// Holds the life cycle multi-bit signal type, the sparse FSM encoding,
// the default ack timeout and small helper functions.
package otp_ctrl_pkg;

    localparam int unsigned LcProgTimeoutCycles = 4096;
    localparam int unsigned LcProgStateWidth    = 9;

    // Life cycle multi-bit boolean; anything other than Off counts as true.
    typedef enum logic [3:0] {
        On  = 4'b0101,
        Off = 4'b1010
    } lc_tx_t;

    // Sparse encoding, pairwise Hamming distance >= 5.
    typedef enum logic [LcProgStateWidth-1:0] {
        IdleSt  = 9'b000000000,
        ReqSt   = 9'b111110000,
        WaitSt  = 9'b110001110,
        AckSt   = 9'b001101101,
        ErrorSt = 9'b101011011
    } lc_prog_state_e;

    // Bits needed to hold values 0..value-1, at least one.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 32'd1) ? 32'd1 : 32'($clog2(value));
    endfunction

    // Fail-safe test: any corrupted encoding is treated as asserted.
    function automatic logic lc_tx_test_true_loose(input logic [3:0] val);
        return val != Off;
    endfunction

endpackage

// File: rtl/prim_count.sv
// Redundant saturating up-counter.
// An up-count and an independently maintained down-count (stored inverted)
// must always agree; any disagreement raises err_o one cycle later.
// Ports: clk_i/rst_i (sync, active high), clr_i (to zero), en_i (count),
//        cnt_o (current value), err_o (registered mismatch flag).
module prim_count #(
    parameter int unsigned       Width  = 4,
    parameter logic [Width-1:0]  MaxVal = {Width{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             err_o
);

    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] inv_q, inv_d;

    // Up path counts from zero, inverted path counts down from all-ones.
    always_comb begin
        cnt_d = cnt_q;
        inv_d = inv_q;
        if (clr_i) begin
            cnt_d = '0;
            inv_d = '1;
        end else if (en_i) begin
            if (cnt_q != MaxVal) begin
                cnt_d = cnt_q + Width'(1);
            end
            if (inv_q != ~MaxVal) begin
                inv_d = inv_q - Width'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            inv_q <= '1;
            err_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inv_q <= inv_d;
            err_o <= (cnt_q != ~inv_q);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/otp_ctrl_lc_prog_stage.sv
// Life cycle programming front stage of the OTP controller.
// Accepts a four-phase program request from the life cycle controller,
// forwards the captured image to the LCI with a single-cycle request,
// waits (bounded) for the LCI completion pulse and answers with ack/err.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lc_prog_req_i/data_i  program request and image from life cycle ctrl
//   lc_prog_ack_o/err_o   four-phase acknowledge and error flag
//   escalate_en_i         escalation (lc_tx_t, loose-true)
//   lci_req_o/data_o      request pulse and held image towards the LCI
//   lci_ack_i/err_i       completion pulse and error from the LCI
//   busy_o                not idle
//   timeout_err_o         sticky LCI ack timeout
//   fsm_err_o             one-cycle pulse on entering ErrorSt abnormally
module otp_ctrl_lc_prog_stage
    import otp_ctrl_pkg::*;
#(
    parameter int unsigned LcDataWidth   = 704,
    parameter int unsigned TimeoutCycles = LcProgTimeoutCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lc_prog_req_i,
    input  logic [LcDataWidth-1:0] lc_prog_data_i,
    output logic                   lc_prog_ack_o,
    output logic                   lc_prog_err_o,
    input  logic [3:0]             escalate_en_i,
    output logic                   lci_req_o,
    output logic [LcDataWidth-1:0] lci_data_o,
    input  logic                   lci_ack_i,
    input  logic                   lci_err_i,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    output logic                   fsm_err_o
);

    localparam int unsigned          CntWidth = vbits(TimeoutCycles);
    localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(TimeoutCycles - 1);

    lc_prog_state_e         state_q, state_d;
    logic [LcDataWidth-1:0] data_d;
    logic                   err_q, err_d;
    logic                   timeout_d;
    logic                   fsm_err_d;
    logic                   lci_req_d;
    logic                   ack_d;
    logic                   prog_err_d;
    logic                   busy_d;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [CntWidth-1:0]    cnt;
    logic                   cnt_err;
    logic                   esc_active;

    assign esc_active = lc_tx_test_true_loose(escalate_en_i);

    // Bounded wait for the LCI completion pulse.
    prim_count #(
        .Width  (CntWidth),
        .MaxVal (CntMax)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .err_o  (cnt_err)
    );

    // Next state, captured data, error bookkeeping and next output values.
    always_comb begin
        state_d   = state_q;
        data_d    = lci_data_o;
        err_d     = err_q;
        timeout_d = timeout_err_o;
        fsm_err_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            IdleSt: begin
                if (lc_prog_req_i && !lc_prog_ack_o) begin
                    data_d  = lc_prog_data_i;
                    cnt_clr = 1'b1;
                    state_d = ReqSt;
                end
            end
            ReqSt: begin
                state_d = WaitSt;
            end
            WaitSt: begin
                cnt_en = 1'b1;
                // A completion in the last allowed cycle still counts.
                if (lci_ack_i) begin
                    err_d   = lci_err_i;
                    state_d = AckSt;
                end else if (cnt == CntMax) begin
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ErrorSt;
                end
            end
            AckSt: begin
                if (!lc_prog_req_i) begin
                    state_d = IdleSt;
                end
            end
            ErrorSt: begin
                state_d = ErrorSt;
            end
            default: begin
                state_d   = ErrorSt;
                fsm_err_d = 1'b1;
            end
        endcase

        // Escalation or a counter integrity fault pre-empts everything else.
        if (esc_active || cnt_err) begin
            state_d   = ErrorSt;
            data_d    = lci_data_o;
            err_d     = err_q;
            timeout_d = timeout_err_o;
            cnt_clr   = 1'b0;
            cnt_en    = 1'b0;
            fsm_err_d = (state_q != ErrorSt);
        end

        lci_req_d  = (state_d == ReqSt);
        ack_d      = (state_d == AckSt) || ((state_d == ErrorSt) && lc_prog_req_i);
        prog_err_d = (state_d == ErrorSt) || ((state_d == AckSt) && err_d);
        busy_d     = (state_d != IdleSt);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IdleSt;
            lci_data_o    <= '0;
            err_q         <= 1'b0;
            timeout_err_o <= 1'b0;
            fsm_err_o     <= 1'b0;
            lci_req_o     <= 1'b0;
            lc_prog_ack_o <= 1'b0;
            lc_prog_err_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lci_data_o    <= data_d;
            err_q         <= err_d;
            timeout_err_o <= timeout_d;
            fsm_err_o     <= fsm_err_d;
            lci_req_o     <= lci_req_d;
            lc_prog_ack_o <= ack_d;
            lc_prog_err_o <= prog_err_d;
            busy_o        <= busy_d;
        end
    end

endmodule

// File: tb/tb_otp_ctrl_lc_prog_stage.sv
// Self-checking bench for otp_ctrl_lc_prog_stage: directed transactions
// plus randomized traffic, all compared against a transaction-level model.
module tb_otp_ctrl_lc_prog_stage;

    localparam int unsigned W = 704;
    localparam int unsigned T = 16;

    logic         clk;
    logic         rst;
    logic         req;
    logic [W-1:0] data;
    logic         ack;
    logic         perr;
    logic [3:0]   esc;
    logic         lci_req;
    logic [W-1:0] lci_data;
    logic         lack;
    logic         lerr;
    logic         busy;
    logic         tmo;
    logic         fsm_err;

    otp_ctrl_lc_prog_stage #(
        .LcDataWidth   (W),
        .TimeoutCycles (T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lc_prog_req_i  (req),
        .lc_prog_data_i (data),
        .lc_prog_ack_o  (ack),
        .lc_prog_err_o  (perr),
        .escalate_en_i  (esc),
        .lci_req_o      (lci_req),
        .lci_data_o     (lci_data),
        .lci_ack_i      (lack),
        .lci_err_i      (lerr),
        .busy_o         (busy),
        .timeout_err_o  (tmo),
        .fsm_err_o      (fsm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model: where the current transaction stands, not how the RTL encodes it.
    bit           m_busy, m_issued, m_answering, m_dead, m_err, m_timeout;
    int           m_waited;
    logic [W-1:0] m_data;
    bit           e_req, e_ack, e_err, e_busy, e_fsm;

    // Observations accumulated for directed end-of-scenario checks.
    int n_pulse, n_fsm;
    bit ack_seen, err_seen;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_update();
        bit escalated;
        escalated = (esc != otp_ctrl_pkg::Off);
        e_fsm = 1'b0;
        if (rst) begin
            m_busy = 0; m_issued = 0; m_answering = 0; m_dead = 0;
            m_err = 0; m_timeout = 0; m_waited = 0; m_data = '0;
        end else if (!m_dead) begin
            if (escalated) begin
                m_dead = 1; e_fsm = 1;
            end else if (!m_busy) begin
                if (req) begin
                    m_busy = 1; m_issued = 0; m_answering = 0; m_waited = 0; m_data = data;
                end
            end else if (!m_issued) begin
                m_issued = 1;
            end else if (!m_answering) begin
                m_waited++;
                if (lack) begin
                    m_answering = 1; m_err = lerr;
                end else if (m_waited == int'(T)) begin
                    m_dead = 1; m_timeout = 1;
                end
            end else if (!req) begin
                m_busy = 0;
            end
        end
        e_req  = m_busy && !m_issued && !m_dead;
        e_ack  = m_dead ? req : (m_busy && m_answering);
        e_err  = m_dead ? 1'b1 : (m_busy && m_answering && m_err);
        e_busy = m_busy || m_dead;
    endtask

    task automatic check_all();
        check_eq($sformatf("c%0d lci_req", cyc),  W'(lci_req), W'(e_req));
        check_eq($sformatf("c%0d ack", cyc),      W'(ack),     W'(e_ack));
        check_eq($sformatf("c%0d err", cyc),      W'(perr),    W'(e_err));
        check_eq($sformatf("c%0d busy", cyc),     W'(busy),    W'(e_busy));
        check_eq($sformatf("c%0d timeout", cyc),  W'(tmo),     W'(m_timeout));
        check_eq($sformatf("c%0d fsm_err", cyc),  W'(fsm_err), W'(e_fsm));
        check_eq($sformatf("c%0d lci_data", cyc), lci_data,    m_data);
    endtask

    task automatic clear_obs();
        n_pulse = 0; n_fsm = 0; ack_seen = 0; err_seen = 0;
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check.
    task automatic step(input bit r, input logic [W-1:0] d, input logic [3:0] e,
                        input bit a, input bit le, input bit rs);
        req = r; data = d; esc = e; lack = a; lerr = le; rst = rs;
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check_all();
        if (lci_req) n_pulse++;
        if (fsm_err) n_fsm++;
        if (ack) begin
            ack_seen = 1;
            if (perr) err_seen = 1;
        end
    endtask

    task automatic do_reset();
        step(0, '0, otp_ctrl_pkg::Off, 0, 0, 1);
        step(0, '0, otp_ctrl_pkg::Off, 0, 0, 1);
        clear_obs();
    endtask

    // One request; LCI ack on wait cycle ack_at (0 = never).
    task automatic txn(input int ack_at, input bit le, input logic [W-1:0] d, input int hold);
        step(1, d, otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        for (int k = 1; k <= int'(T); k++) begin
            step(1, rand_data(), otp_ctrl_pkg::Off, k == ack_at, le, 0);
            if (k == ack_at) break;
        end
        for (int h = 0; h < hold; h++) step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(0, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(0, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] dx;
        logic [W-1:0] dy;
        a5 = {88{8'hA5}};
        req = 0; data = '0; esc = otp_ctrl_pkg::Off; lack = 0; lerr = 0; rst = 1;
        @(negedge clk);

        // Reset state.
        do_reset();
        check_eq("rst_busy", W'(busy), W'(0));
        check_eq("rst_data", lci_data, '0);

        // Normal transaction, clean completion after 3 wait cycles.
        txn(3, 0, a5, 2);
        check_eq("ok_pulses", W'(n_pulse), W'(1));
        check_eq("ok_data", lci_data, a5);
        check_eq("ok_ack_seen", W'(ack_seen), W'(1));
        check_eq("ok_err_seen", W'(err_seen), W'(0));
        check_eq("ok_idle", W'(busy), W'(0));

        // LCI reports a programming error.
        clear_obs();
        txn(3, 1, a5, 1);
        check_eq("lcierr_ack_seen", W'(ack_seen), W'(1));
        check_eq("lcierr_err_seen", W'(err_seen), W'(1));
        check_eq("lcierr_tmo", W'(tmo), W'(0));

        // No LCI ack: timeout into the terminal error state.
        clear_obs();
        txn(0, 0, rand_data(), 2);
        check_eq("tmo_sticky", W'(tmo), W'(1));
        check_eq("tmo_busy", W'(busy), W'(1));
        clear_obs();
        for (int i = 0; i < 3; i++) step(1, rand_data(), otp_ctrl_pkg::Off, 1, 0, 0);
        check_eq("dead_ack", W'(ack), W'(1));
        check_eq("dead_err", W'(perr), W'(1));
        check_eq("dead_no_lci_req", W'(n_pulse), W'(0));

        // Ack in the very last wait cycle beats the timeout.
        do_reset();
        txn(int'(T), 0, rand_data(), 1);
        check_eq("late_ack_tmo", W'(tmo), W'(0));
        check_eq("late_ack_seen", W'(ack_seen), W'(1));
        check_eq("late_ack_idle", W'(busy), W'(0));

        // Escalation while waiting for the LCI.
        do_reset();
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, rand_data(), otp_ctrl_pkg::On, 0, 0, 0);
        check_eq("esc_fsm_pulses", W'(n_fsm), W'(1));
        check_eq("esc_busy", W'(busy), W'(1));

        // Reset mid-wait abandons the transaction; a fresh one follows.
        do_reset();
        dx = rand_data();
        dy = rand_data();
        step(1, dx, otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        step(1, rand_data(), otp_ctrl_pkg::Off, 0, 0, 1);
        check_eq("midrst_lci_req", W'(lci_req), W'(0));
        check_eq("midrst_ack", W'(ack), W'(0));
        step(0, rand_data(), otp_ctrl_pkg::Off, 0, 0, 0);
        clear_obs();
        txn(2, 0, dy, 1);
        check_eq("fresh_pulses", W'(n_pulse), W'(1));
        check_eq("fresh_data", lci_data, dy);

        // Randomized traffic.
        for (int s = 0; s < 40; s++) begin
            int ack_pct;
            int esc_pct;
            int keep;
            bit r;
            logic [3:0] e;
            ack_pct = (s % 4 == 0) ? 0 : int'($urandom_range(5, 50));
            esc_pct = (s % 5 == 4) ? 4 : 0;
            r = 1'b0;
            step(0, rand_data(), otp_ctrl_pkg::Off, 0, 0, 1);
            for (int c = 0; c < 80; c++) begin
                if (e_ack)  keep = 40;
                else if (r) keep = 90;
                else        keep = 30;
                r = (int'($urandom_range(0, 99)) < keep);
                e = otp_ctrl_pkg::Off;
                if (int'($urandom_range(0, 99)) < esc_pct)
                    e = ($urandom_range(0, 1) == 1) ? otp_ctrl_pkg::On : 4'($urandom());
                step(r, rand_data(), e,
                     int'($urandom_range(0, 99)) < ack_pct,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 299) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/otp_ctrl_lc_prog_stage.md
OTP_CTRL_LC_PROG_STAGE -- requirements
Module: otp_ctrl_lc_prog_stage

Interface
REQ-001 SHALL have parameter LcDataWidth, default 704, width of the life cycle partition programming word (partition size x 8).
REQ-002 SHALL have parameter TimeoutCycles, default 4096, max cycles to wait for an LCI ack; legal range 2..65536.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port lc_prog_req_i  input  1  four-phase program request from the life cycle controller.
REQ-006 SHALL have port lc_prog_data_i  input  LcDataWidth  target state+count image; valid while lc_prog_req_i is high.
REQ-007 SHALL have port lc_prog_ack_o  output  1  four-phase acknowledge to the life cycle controller.
REQ-008 SHALL have port lc_prog_err_o  output  1  error flag; valid whenever lc_prog_ack_o is high.
REQ-009 SHALL have port escalate_en_i  input  4 (lc_tx_t)  escalation; loose-true test.
REQ-010 SHALL have port lci_req_o  output  1  single-cycle request pulse to the LCI programming stage.
REQ-011 SHALL have port lci_data_o  output  LcDataWidth  registered programming image to the LCI.
REQ-012 SHALL have port lci_ack_i  input  1  single-cycle completion pulse from the LCI.
REQ-013 SHALL have port lci_err_i  input  1  LCI programming error; sampled only with lci_ack_i.
REQ-014 SHALL have port busy_o  output  1  high in every state except IdleSt.
REQ-015 SHALL have port timeout_err_o  output  1  sticky; set on ack timeout.
REQ-016 SHALL have port fsm_err_o  output  1  one-cycle pulse on invalid state encoding or escalation.

Function
REQ-017 SHALL implement FSM states IdleSt, ReqSt, WaitSt, AckSt, ErrorSt with sparse encoding (9 bits, min Hamming distance 5).
REQ-018 IdleSt: lc_prog_req_i high and lc_prog_ack_o low -> capture lc_prog_data_i into lci_data_o, clear timeout counter, go ReqSt.
REQ-019 ReqSt: lci_req_o=1 for exactly this one cycle; unconditionally go WaitSt next cycle.
REQ-020 WaitSt: counter increments each cycle; lci_ack_i=1 -> latch lci_err_i into err register, go AckSt.
REQ-021 WaitSt: counter reaches TimeoutCycles-1 without lci_ack_i -> set timeout_err_o, set err register, go ErrorSt; ack in the same cycle wins over timeout.
REQ-022 AckSt: lc_prog_ack_o=1, lc_prog_err_o=err register; on lc_prog_req_i low go IdleSt; if req already low on entry, ack lasts exactly one cycle.
REQ-023 lc_prog_req_i deasserting in ReqSt/WaitSt SHALL NOT abort the transaction; completion proceeds through AckSt.
REQ-024 lci_data_o SHALL remain stable from capture until next IdleSt capture; never changes during ReqSt/WaitSt/AckSt.
REQ-025 ErrorSt terminal: lc_prog_ack_o = lc_prog_req_i, lc_prog_err_o=1, lci_req_o=0; exits only by reset.
REQ-026 Escalation (loose true) in any state -> ErrorSt next cycle, fsm_err_o pulse; overrides all other transitions.
REQ-027 Invalid state encoding -> ErrorSt, fsm_err_o=1 in that cycle.
REQ-028 lci_ack_i outside WaitSt SHALL be ignored.
REQ-029 Timeout counter width SHALL be vbits(TimeoutCycles); no wrap (saturates at limit).

Reset
REQ-030 rst_i high at a clock edge -> IdleSt; lci_data_o, err register, counter = 0; all outputs 0 from the following cycle.
REQ-031 Reset mid-transaction SHALL abandon it; lci_req_o low and lc_prog_ack_o low in the first post-reset cycle.

Structure
REQ-032 State encoding typedef and TimeoutCycles default SHALL live in otp_ctrl_pkg.
REQ-033 Timeout counter SHALL be a sub-module prim_count instance (redundant counter, err_o feeding ErrorSt like escalation).

Verification (TimeoutCycles=16, LcDataWidth=704)
REQ-034 req=1, data=0xA5..A5; LCI ack after 3 cycles, err=0 -> one lci_req_o pulse, lci_data_o=0xA5..A5, ack=1 err=0 until req drops, then IdleSt.
REQ-035 Same, lci_err_i=1 with ack -> lc_prog_ack_o=1, lc_prog_err_o=1, timeout_err_o=0.
REQ-036 No LCI ack -> ErrorSt after 16 WaitSt cycles, timeout_err_o=1; later req=1 -> ack=1 err=1, lci_req_o stays 0.
REQ-037 Ack arriving in WaitSt cycle 16 -> AckSt, timeout_err_o=0.
REQ-038 escalate_en_i=On during WaitSt -> ErrorSt next cycle, fsm_err_o one-cycle pulse.
REQ-039 rst_i asserted in WaitSt, then new req -> fresh transaction, single lci_req_o pulse, prior data discarded.
